// File: rtl/z80_bus_responder_if.sv
// Z80 responder bus bundle: the CPU-side strobes and data, plus the level
// req/ack handshake toward the backing target.
interface z80_bus_responder_if;
  // CPU side
  logic        mreq;
  logic        iorq;
  logic        rd;
  logic        wr;
  logic        m1;
  logic        rfsh;
  logic [15:0] a;
  logic [7:0]  q;
  logic [7:0]  d;
  logic        wait_n;
  // Target side
  logic        req;
  logic        we;
  logic        io;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ack;
  logic [7:0]  rdata;
  logic        timeout;

  // Responder view: samples CPU strobes and target completion, drives the rest.
  modport slave (
    input  mreq, iorq, rd, wr, m1, rfsh, a, q, ack, rdata,
    output d, wait_n, req, we, io, addr, wdata, timeout
  );

  // CPU/target view: the environment the responder sits between.
  modport master (
    output mreq, iorq, rd, wr, m1, rfsh, a, q, ack, rdata,
    input  d, wait_n, req, we, io, addr, wdata, timeout
  );
endinterface

// File: rtl/z80_bus_responder.sv
// Z80 bus responder: converts each CPU memory/IO cycle into one req/ack
// transaction, stretches the CPU with wait_n, and returns read data or the
// interrupt-acknowledge vector on d.
module z80_bus_responder #(
  parameter int         TIMEOUT   = 255,
  parameter logic [7:0] IDLE_DATA = 8'hFF,
  parameter logic [7:0] IACK_VEC  = 8'hFF
) (
  input logic                 clock,
  input logic                 reset,
  z80_bus_responder_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          cyc_io;   // cycle was started by IORQ (IO or IACK), not MREQ

  logic is_iack;
  logic is_io;
  logic is_mem;
  logic hold_done;

  // Cycle classification from the raw active-low strobes; IACK > IO > MEM
  // priority is applied by the order of tests in the IDLE state.
  assign is_iack   = ~bus.iorq & ~bus.m1;
  assign is_io     = ~bus.iorq &  bus.m1   & (~bus.rd | ~bus.wr);
  assign is_mem    = ~bus.mreq &  bus.rfsh & (~bus.rd | ~bus.wr);
  // The CPU cycle is over once both data strobes and the originating
  // address-space strobe have returned high.
  assign hold_done = bus.rd & bus.wr & (cyc_io ? bus.iorq : bus.mreq);

  // Transaction FSM with all bus outputs registered.
  // NOTE: every state and output register uses <= so all of them update
  // together on the edge; a blocking = here would let later statements see
  // this edge's new values and create order-dependent behaviour.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      count       <= '0;
      cyc_io      <= 1'b0;
      bus.req     <= 1'b0;
      bus.we      <= 1'b0;
      bus.io      <= 1'b0;
      bus.addr    <= '0;
      bus.wdata   <= '0;
      bus.wait_n  <= 1'b1;
      bus.d       <= IDLE_DATA;
      bus.timeout <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (is_iack) begin
            bus.d  <= IACK_VEC;
            cyc_io <= 1'b1;
            state  <= S_HOLD;
          end else if (is_io || is_mem) begin
            bus.req    <= 1'b1;
            bus.wait_n <= 1'b0;
            bus.we     <= ~bus.wr;
            bus.io     <= is_io;
            bus.addr   <= bus.a;
            bus.wdata  <= bus.q;
            cyc_io     <= is_io;
            count      <= '0;
            state      <= S_REQ;
          end
        end

        S_REQ: begin
          // Width covers TIMEOUT, so the final increment on exit cannot wrap.
          count <= count + CW'(1);
          if (bus.ack) begin
            bus.req    <= 1'b0;
            bus.wait_n <= 1'b1;
            if (!bus.we) bus.d <= bus.rdata;
            state <= S_HOLD;
          end else if (count == LAST) begin
            bus.req     <= 1'b0;
            bus.wait_n  <= 1'b1;
            bus.timeout <= 1'b1;
            if (!bus.we) bus.d <= IDLE_DATA;
            state <= S_HOLD;
          end
        end

        S_HOLD: begin
          // Forces at least one IDLE clock so one CPU cycle is serviced once.
          if (hold_done) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
